// File: rtl/saci_slave_core.sv
// saci_slave_core: SACI serial slave with configurable field widths.
// Deserialises command frames, runs the exec/ack handshake, serialises the response.
module saci_slave_core #(
  parameter int CMD_W       = 7,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              rstL,
  input  logic              saciSelL,
  input  logic              saciCmd,
  output logic              saciRsp,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrData,
  output logic              readL,
  output logic              exec,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdData,
  output logic              rstOutL,
  output logic              timeout
);

  localparam int HDR_W = 1 + CMD_W + ADDR_W;
  localparam int RSP_W = HDR_W + DATA_W;
  localparam int CNT_W = $clog2(RSP_W + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(RSP_W);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, EXEC, ACK_LOW, RESP, DONE
  } state_t;

  state_t state, nextState;

  logic [CNT_W-1:0]  bitCnt;
  logic [TMO_W-1:0]  tmoCnt;
  logic [HDR_W-2:0]  hdrSr;
  logic [DATA_W-2:0] dataSr;
  logic [RSP_W-1:0]  rspSr;
  logic [1:0]        rstSync;
  logic [HDR_W-1:0]  hdrFull;
  logic [DATA_W-1:0] dataFull;
  logic              waiting;
  logic              tmoHit;
  logic              stay;

  assign hdrFull  = {hdrSr, saciCmd};
  assign dataFull = {dataSr, saciCmd};
  assign waiting  = (state == EXEC) || (state == ACK_LOW);
  assign tmoHit   = waiting && !saciSelL && (tmoCnt == TMO_LAST);
  assign stay     = (nextState == state);

  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) state <= IDLE;
    else       state <= nextState;
  end

  // Deselect aborts from any state; timeout outranks the handshake.
  always_comb begin
    nextState = state;
    if (state != IDLE && saciSelL) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!saciSelL && saciCmd) nextState = HDR;
        HDR:     if (bitCnt == HDR_LAST)
                   nextState = hdrFull[HDR_W-1] ? DATA : EXEC;
        DATA:    if (bitCnt == DAT_LAST) nextState = EXEC;
        EXEC:    if (tmoHit)   nextState = RESP;
                 else if (ack) nextState = ACK_LOW;
        ACK_LOW: if (tmoHit || !ack) nextState = RESP;
        RESP:    if (bitCnt == RSP_LAST) nextState = DONE;
        DONE:    nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    exec = (state == EXEC);
  end

  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) begin
      bitCnt  <= '0;
      tmoCnt  <= '0;
      hdrSr   <= '0;
      dataSr  <= '0;
      rspSr   <= '0;
      cmd     <= '0;
      addr    <= '0;
      wrData  <= '0;
      readL   <= 1'b1;
      saciRsp <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmoHit;
      bitCnt  <= stay ? bitCnt + 1'b1 : '0;
      tmoCnt  <= (waiting && (nextState == EXEC || nextState == ACK_LOW))
                 ? tmoCnt + 1'b1 : '0;
      if (state == HDR) begin
        hdrSr <= hdrFull[HDR_W-2:0];
        if (!stay && nextState != IDLE) begin
          readL <= hdrFull[HDR_W-1];
          cmd   <= hdrFull[HDR_W-2 -: CMD_W];
          addr  <= hdrFull[ADDR_W-1:0];
        end
      end
      if (state == DATA) begin
        dataSr <= dataFull[DATA_W-2:0];
        if (nextState == EXEC) wrData <= dataFull;
      end
      if (tmoHit)
        rspSr <= {readL, cmd, addr, {DATA_W{1'b1}}};
      else if (state == EXEC && nextState == ACK_LOW)
        rspSr <= {readL, cmd, addr, readL ? wrData : rdData};
      else if (state == RESP && stay)
        rspSr <= rspSr << 1;
      if (nextState == RESP && !stay)
        saciRsp <= 1'b1;
      else if (state == RESP && stay)
        saciRsp <= rspSr[RSP_W-1];
      else
        saciRsp <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) rstSync <= 2'b00;
    else       rstSync <= {rstSync[0], 1'b1};
  end

  assign rstOutL = rstSync[1];

endmodule

// File: tb/tb_saci_slave_core.sv
// tb_saci_slave_core: randomized frames against a field-level model.
// Two instances cover default and narrow field widths.
module tb_saci_slave_core;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rstL;
  logic        selL;
  logic        cmdIn;
  logic        ack;
  logic        useB;
  logic [31:0] rdData;

  logic        rspA, readLA, execA, rstOutA, tmoA;
  logic [6:0]  cmdA;
  logic [11:0] addrA;
  logic [31:0] wrA;
  logic        rspB, readLB, execB, rstOutB, tmoB;
  logic [4:0]  cmdB;
  logic [7:0]  addrB;
  logic [15:0] wrB;

  logic        selLA, selLB;
  logic        rspM, execM, readLM, tmoM, rstOutM;
  logic [31:0] cmdM, addrM, wrM;

  assign selLA   = useB ? 1'b1 : selL;
  assign selLB   = useB ? selL : 1'b1;
  assign rspM    = useB ? rspB : rspA;
  assign execM   = useB ? execB : execA;
  assign readLM  = useB ? readLB : readLA;
  assign tmoM    = useB ? tmoB : tmoA;
  assign rstOutM = useB ? rstOutB : rstOutA;
  assign cmdM    = useB ? 32'(cmdB) : 32'(cmdA);
  assign addrM   = useB ? 32'(addrB) : 32'(addrA);
  assign wrM     = useB ? 32'(wrB) : wrA;

  saci_slave_core #(
    .CMD_W(7), .ADDR_W(12), .DATA_W(32), .ACK_TIMEOUT(16)
  ) dutA (
    .CLK(CLK), .rstL(rstL), .saciSelL(selLA), .saciCmd(cmdIn),
    .saciRsp(rspA), .cmd(cmdA), .addr(addrA), .wrData(wrA),
    .readL(readLA), .exec(execA), .ack(ack), .rdData(rdData),
    .rstOutL(rstOutA), .timeout(tmoA)
  );

  saci_slave_core #(
    .CMD_W(5), .ADDR_W(8), .DATA_W(16), .ACK_TIMEOUT(16)
  ) dutB (
    .CLK(CLK), .rstL(rstL), .saciSelL(selLB), .saciCmd(cmdIn),
    .saciRsp(rspB), .cmd(cmdB), .addr(addrB), .wrData(wrB),
    .readL(readLB), .exec(execB), .ack(ack), .rdData(rdData[15:0]),
    .rstOutL(rstOutB), .timeout(tmoB)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Register bank: ack after ackDly cycles of exec, one-cycle ack pulse.
  int ackDly = 0;
  int waitCnt = 0;
  bit bankOff = 1'b0;

  initial begin
    ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack) begin
        ack = 1'b0;
        waitCnt = 0;
      end else if (execM && !bankOff) begin
        if (waitCnt >= ackDly) ack = 1'b1;
        else waitCnt++;
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic xact(input bit op, input logic [31:0] c, a, d, rd,
                      input int dly, input bit noAck, input int abortAt,
                      input bit rstMid);
    int cw, aw, dw, fl, rw, execCyc, tmoCnt;
    bit seen, found, bad;
    logic [31:0] cm, am, dm, dExp, sReadL, sCmd, sAddr, sWr, wrBefore;
    logic [63:0] frm, exp, got;
    cw = useB ? 5 : 7;
    aw = useB ? 8 : 12;
    dw = useB ? 16 : 32;
    cm = c & msk(cw);
    am = a & msk(aw);
    dm = d & msk(dw);
    rdData = rd;
    ackDly = dly;
    bankOff = noAck;
    wrBefore = wrM;
    frm = 64'd1;
    frm = (frm << 1) | 64'(op);
    frm = (frm << cw) | 64'(cm);
    frm = (frm << aw) | 64'(am);
    if (op) frm = (frm << dw) | 64'(dm);
    fl = 2 + cw + aw + (op ? dw : 0);
    rw = 1 + cw + aw + dw;
    for (int i = 0; i < fl; i++) begin
      @(negedge CLK);
      if (i == abortAt) begin
        selL = 1'b1;
        cmdIn = 1'b0;
        bad = 1'b0;
        repeat (4) begin
          @(negedge CLK);
          if (execM || rspM) bad = 1'b1;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        check("abort_wrData", 64'(wrM), 64'(wrBefore));
        return;
      end
      selL = 1'b0;
      cmdIn = frm[fl-1-i];
    end
    dExp = noAck ? msk(dw) : (op ? dm : (rd & msk(dw)));
    exp = 64'(op);
    exp = (exp << cw) | 64'(cm);
    exp = (exp << aw) | 64'(am);
    exp = (exp << dw) | 64'(dExp);
    seen = 1'b0;
    found = 1'b0;
    execCyc = 0;
    tmoCnt = 0;
    sReadL = '0; sCmd = '0; sAddr = '0; sWr = '0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge CLK);
      cmdIn = 1'b0;
      if (tmoM) tmoCnt++;
      if (execM) begin
        execCyc++;
        if (!seen) begin
          seen = 1'b1;
          sReadL = 32'(readLM);
          sCmd = cmdM;
          sAddr = addrM;
          sWr = wrM;
        end
      end
      if (rspM) found = 1'b1;
    end
    check("rsp_start", 64'(found), 64'd1);
    check("exec_seen", 64'(seen), 64'd1);
    check("readL", 64'(sReadL), 64'(op));
    check("cmd", 64'(sCmd), 64'(cm));
    check("addr", 64'(sAddr), 64'(am));
    check("wrData", 64'(sWr), 64'(op ? dm : wrBefore));
    if (noAck) check("exec_cycles", 64'(execCyc), 64'd16);
    got = '0;
    for (int k = 0; k < rw; k++) begin
      @(negedge CLK);
      if (rstMid && k == 5) begin
        rstL = 1'b0;
        #1;
        check("rst_rsp", 64'(rspM), 64'd0);
        check("rst_exec", 64'(execM), 64'd0);
        check("rst_out", 64'(rstOutM), 64'd0);
        check("rst_cmd", 64'(cmdM), 64'd0);
        selL = 1'b1;
        @(negedge CLK);
        rstL = 1'b1;
        @(negedge CLK);
        check("rstout_edge1", 64'(rstOutM), 64'd0);
        @(negedge CLK);
        check("rstout_edge2", 64'(rstOutM), 64'd1);
        return;
      end
      got = (got << 1) | 64'(rspM);
      if (tmoM) tmoCnt++;
    end
    @(negedge CLK);
    check("rsp_end", 64'(rspM), 64'd0);
    check("rsp_frame", got, exp);
    check("timeout_pulses", 64'(tmoCnt), noAck ? 64'd1 : 64'd0);
    selL = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    bit bad;
    rstL = 1'b0;
    selL = 1'b1;
    cmdIn = 1'b0;
    useB = 1'b0;
    rdData = '0;
    repeat (2) @(negedge CLK);
    check("reset_exec", 64'(execM), 64'd0);
    check("reset_readL", 64'(readLM), 64'd1);
    check("reset_rsp", 64'(rspM), 64'd0);
    check("reset_tmo", 64'(tmoM), 64'd0);
    check("reset_rstOut", 64'(rstOutM), 64'd0);
    check("reset_cmd", 64'(cmdM), 64'd0);
    check("reset_addr", 64'(addrM), 64'd0);
    check("reset_wr", 64'(wrM), 64'd0);
    rstL = 1'b1;
    @(negedge CLK);
    check("rel_edge1", 64'(rstOutM), 64'd0);
    @(negedge CLK);
    check("rel_edge2", 64'(rstOutM), 64'd1);

    selL = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (execM || rspM) bad = 1'b1;
    end
    check("idle_nostart", 64'(bad), 64'd0);

    xact(1, 32'h15, 32'hABC, 32'hDEADBEEF, 32'h0, 3, 0, -1, 0);
    xact(0, 32'h02, 32'h001, 32'h0, 32'h12345678, 1, 0, -1, 0);
    xact(1, 32'h33, 32'h456, 32'hCAFEF00D, 32'h0, 0, 1, -1, 0);
    xact(0, 32'h7F, 32'hFFF, 32'h0, 32'h0BADBEEF, 0, 1, -1, 0);
    xact(1, 32'h11, 32'h222, 32'h0BADF00D, 32'h0, 2, 0, 2 + 7 + 12 + 10, 0);
    xact(1, 32'h2A, 32'h555, 32'h89ABCDEF, 32'h0, 2, 0, -1, 0);
    for (int n = 0; n < 10; n++)
      xact(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
           int'($urandom_range(0, 4)), 0, -1, 0);
    xact(1, $urandom, $urandom, $urandom, 32'h0, 1, 0, -1, 1);
    xact(0, $urandom, $urandom, 32'h0, $urandom, 2, 0, -1, 0);

    useB = 1'b1;
    repeat (2) @(negedge CLK);
    xact(1, 32'h1F, 32'h80, 32'hA5A5, 32'h0, 2, 0, -1, 0);
    xact(0, 32'h03, 32'h7E, 32'h0, 32'h5A5A, 1, 0, -1, 0);
    xact(1, 32'h04, 32'h10, 32'h1234, 32'h0, 0, 1, -1, 0);
    for (int n = 0; n < 5; n++)
      xact(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
           int'($urandom_range(0, 4)), 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
